// File: rtl/button_events.sv
// -----------------------------------------------------------------------------
// button_events
//   N-channel pushbutton front end. Each raw input is polarity-corrected,
//   passed through a 2-flop synchroniser, and debounced on both press and
//   release by a small per-channel FSM. Emits registered one-cycle events:
//   press (debounced rising edge), click (release after a short press),
//   long (press held for LONG_TICKS) and rep (auto-repeat while long).
//
// Ports
//   clk    in  1  system clock
//   reset  in  1  asynchronous active-high reset
//   raw    in  N  unsynchronised button levels (polarity set by ACTIVE_LOW)
//   held   out N  debounced pressed level
//   press  out N  one-cycle pulse when held rises
//   click  out N  one-cycle pulse when held falls after a short press
//   long   out N  one-cycle pulse when a press becomes long
//   rep    out N  one-cycle auto-repeat pulse
// -----------------------------------------------------------------------------
module button_events #(
  parameter int N           = 4,
  parameter int CLK_HZ      = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 600,
  parameter int REPEAT_MS   = 200,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] raw,
  output logic [N-1:0] held,
  output logic [N-1:0] press,
  output logic [N-1:0] click,
  output logic [N-1:0] long,
  output logic [N-1:0] rep
);

  localparam int DB_TICKS   = (CLK_HZ / 32'sd1000) * DEBOUNCE_MS;
  localparam int LONG_TICKS = (CLK_HZ / 32'sd1000) * LONG_MS;
  localparam int REP_TICKS  = (CLK_HZ / 32'sd1000) * REPEAT_MS;

  localparam bit DB_ONE = (DB_TICKS == 32'sd1);
  localparam bit REP_EN = (REP_TICKS != 32'sd0);

  localparam int DCW  = (DB_TICKS > 32'sd1) ? $clog2(DB_TICKS) : 32'sd1;
  localparam int LW   = $clog2(LONG_TICKS);
  localparam int RW   = (REP_TICKS > 32'sd1) ? $clog2(REP_TICKS) : 32'sd1;
  localparam int HCW0 = (LW > RW) ? LW : RW;
  localparam int HCW  = (HCW0 > 32'sd0) ? HCW0 : 32'sd1;

  localparam int REP_LAST_I = REP_EN ? (REP_TICKS - 32'sd1) : 32'sd0;

  localparam logic [DCW-1:0] DB_LAST   = DCW'(DB_TICKS - 32'sd1);
  localparam logic [HCW-1:0] LONG_LAST = HCW'(LONG_TICKS - 32'sd1);
  localparam logic [HCW-1:0] REP_LAST  = HCW'(REP_LAST_I);
  localparam logic [DCW-1:0] DC_ZERO   = '0;
  localparam logic [DCW-1:0] DC_ONE    = DCW'(32'sd1);
  localparam logic [HCW-1:0] HC_ZERO   = '0;
  localparam logic [HCW-1:0] HC_ONE    = HCW'(32'sd1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_e;

  // Polarity correction: p is 1 when the button is pressed.
  logic [N-1:0] p_s;
  assign p_s = raw ^ {N{ACTIVE_LOW}};

  logic [N-1:0]   sync1_q, sync1_d;
  logic [N-1:0]   sync2_q, sync2_d;
  state_e         state_q [N];
  state_e         state_d [N];
  logic [DCW-1:0] dcnt_q  [N];
  logic [DCW-1:0] dcnt_d  [N];
  logic [HCW-1:0] hcnt_q  [N];
  logic [HCW-1:0] hcnt_d  [N];
  logic [N-1:0]   is_long_q, is_long_d;
  logic [N-1:0]   held_q, held_d;
  logic [N-1:0]   press_q, press_d;
  logic [N-1:0]   click_q, click_d;
  logic [N-1:0]   long_q, long_d;
  logic [N-1:0]   rep_q, rep_d;

  // Transition strobes from the next-state logic into the output logic.
  logic [N-1:0]   go_held_s;
  logic [N-1:0]   go_idle_s;

  // Synchroniser stages.
  assign sync1_d = p_s;
  assign sync2_d = sync1_q;

  // State register: all flops reset asynchronously to "not pressed / idle".
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      is_long_q <= '0;
      held_q    <= '0;
      press_q   <= '0;
      click_q   <= '0;
      long_q    <= '0;
      rep_q     <= '0;
      for (int i = 0; i < N; i++) begin
        state_q[i] <= IDLE;
        dcnt_q[i]  <= DC_ZERO;
        hcnt_q[i]  <= HC_ZERO;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      is_long_q <= is_long_d;
      held_q    <= held_d;
      press_q   <= press_d;
      click_q   <= click_d;
      long_q    <= long_d;
      rep_q     <= rep_d;
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        dcnt_q[i]  <= dcnt_d[i];
        hcnt_q[i]  <= hcnt_d[i];
      end
    end
  end

  // Next-state logic: debounce FSM and debounce counter per channel.
  always_comb begin
    go_held_s = '0;
    go_idle_s = '0;
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      dcnt_d[i]  = dcnt_q[i];
      case (state_q[i])
        IDLE: begin
          if (sync2_q[i]) begin
            if (DB_ONE) begin
              state_d[i]   = HELD;
              dcnt_d[i]    = DC_ZERO;
              go_held_s[i] = 1'b1;
            end else begin
              state_d[i] = PRESS_DB;
              dcnt_d[i]  = DC_ONE;
            end
          end else begin
            dcnt_d[i] = DC_ZERO;
          end
        end
        PRESS_DB: begin
          if (!sync2_q[i]) begin
            // Glitch shorter than the debounce window: silently drop it.
            state_d[i] = IDLE;
            dcnt_d[i]  = DC_ZERO;
          end else if (dcnt_q[i] == DB_LAST) begin
            state_d[i]   = HELD;
            dcnt_d[i]    = DC_ZERO;
            go_held_s[i] = 1'b1;
          end else begin
            dcnt_d[i] = dcnt_q[i] + DC_ONE;
          end
        end
        HELD: begin
          if (!sync2_q[i]) begin
            if (DB_ONE) begin
              state_d[i]   = IDLE;
              dcnt_d[i]    = DC_ZERO;
              go_idle_s[i] = 1'b1;
            end else begin
              state_d[i] = REL_DB;
              dcnt_d[i]  = DC_ONE;
            end
          end else begin
            dcnt_d[i] = DC_ZERO;
          end
        end
        REL_DB: begin
          if (sync2_q[i]) begin
            // Release bounce: back to HELD without touching hold timing.
            state_d[i] = HELD;
            dcnt_d[i]  = DC_ZERO;
          end else if (dcnt_q[i] == DB_LAST) begin
            state_d[i]   = IDLE;
            dcnt_d[i]    = DC_ZERO;
            go_idle_s[i] = 1'b1;
          end else begin
            dcnt_d[i] = dcnt_q[i] + DC_ONE;
          end
        end
        default: begin
          state_d[i] = IDLE;
          dcnt_d[i]  = DC_ZERO;
        end
      endcase
    end
  end

  // Output logic: held level, event pulses and hold/repeat timing.
  // The press and release edges take priority over hold counting, which keeps
  // press/long/rep/click mutually exclusive and stops a long or rep pulse from
  // landing in the same cycle that held falls.
  always_comb begin
    held_d    = held_q;
    is_long_d = is_long_q;
    press_d   = '0;
    click_d   = '0;
    long_d    = '0;
    rep_d     = '0;
    for (int i = 0; i < N; i++) begin
      hcnt_d[i] = hcnt_q[i];
      if (go_held_s[i]) begin
        held_d[i]    = 1'b1;
        press_d[i]   = 1'b1;
        hcnt_d[i]    = HC_ZERO;
        is_long_d[i] = 1'b0;
      end else if (go_idle_s[i]) begin
        held_d[i]    = 1'b0;
        click_d[i]   = ~is_long_q[i];
        hcnt_d[i]    = HC_ZERO;
        is_long_d[i] = 1'b0;
      end else if ((state_q[i] == HELD) || (state_q[i] == REL_DB)) begin
        if (!is_long_q[i]) begin
          if (hcnt_q[i] == LONG_LAST) begin
            long_d[i]    = 1'b1;
            is_long_d[i] = 1'b1;
            hcnt_d[i]    = HC_ZERO;
          end else begin
            hcnt_d[i] = hcnt_q[i] + HC_ONE;
          end
        end else if (REP_EN) begin
          if (hcnt_q[i] == REP_LAST) begin
            rep_d[i]  = 1'b1;
            hcnt_d[i] = HC_ZERO;
          end else begin
            hcnt_d[i] = hcnt_q[i] + HC_ONE;
          end
        end else begin
          // Repeat disabled: nothing left to time once long.
          hcnt_d[i] = hcnt_q[i];
        end
      end else begin
        hcnt_d[i] = hcnt_q[i];
      end
    end
  end

  assign held  = held_q;
  assign press = press_q;
  assign click = click_q;
  assign long  = long_q;
  assign rep   = rep_q;

endmodule

// File: tb/tb_button_events.sv
module tb_button_events;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] raw;
  logic [3:0] held, press, click, long_o, rep;

  always #5 clk = ~clk;

  button_events #(
    .N(4), .CLK_HZ(1000), .DEBOUNCE_MS(4), .LONG_MS(20), .REPEAT_MS(5), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(rst), .raw(raw),
    .held(held), .press(press), .click(click), .long(long_o), .rep(rep)
  );

  // One button transaction with hand-computed event times (cycle numbers
  // counted in rising edges after the first drive; 0 means "no such event").
  typedef struct {
    int scen;
    int ch;
    int start;
    int len;
    int b_at;
    int b_len;
    int press_at;
    int long_at;
    int rep_first;
    int rep_last;
    int fall_at;
    int click;
  } txn_t;

  localparam int NT = 9;
  localparam int NS = 8;
  txn_t tbl [NT];

  int checks   = 0;
  int failures = 0;

  function automatic logic [19:0] pack(input logic [3:0] h, input logic [3:0] p,
                                       input logic [3:0] c, input logic [3:0] l,
                                       input logic [3:0] r);
    return {h, p, c, l, r};
  endfunction

  function automatic logic [19:0] outs();
    return {held, press, click, long_o, rep};
  endfunction

  task automatic check(input string name, input int t, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got held/press/click/long/rep=%h expected %h", name, t, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] expect_at(input int scen, input int t);
    logic [19:0] e;
    e = 20'h0;
    for (int r = 0; r < NT; r++) begin
      if (tbl[r].scen == scen) begin
        int c;
        c = tbl[r].ch;
        if (tbl[r].press_at != 0 && t >= tbl[r].press_at && t < tbl[r].fall_at) e[16 + c] = 1'b1;
        if (tbl[r].press_at != 0 && t == tbl[r].press_at) e[12 + c] = 1'b1;
        if (tbl[r].click != 0 && t == tbl[r].fall_at) e[8 + c] = 1'b1;
        if (tbl[r].long_at != 0 && t == tbl[r].long_at) e[4 + c] = 1'b1;
        if (tbl[r].rep_first != 0 && t >= tbl[r].rep_first && t <= tbl[r].rep_last &&
            ((t - tbl[r].rep_first) % 5) == 0) e[c] = 1'b1;
      end
    end
    return e;
  endfunction

  // Raw value driven just after edge t (active-low: 0 = pressed).
  function automatic logic [3:0] raw_at(input int scen, input int t);
    logic [3:0] v;
    v = 4'hF;
    for (int r = 0; r < NT; r++) begin
      if (tbl[r].scen == scen && t >= tbl[r].start && t < tbl[r].start + tbl[r].len &&
          !(tbl[r].b_len > 0 && t >= tbl[r].b_at && t < tbl[r].b_at + tbl[r].b_len))
        v[tbl[r].ch] = 1'b0;
    end
    return v;
  endfunction

  task automatic run_scen(input int scen);
    int tmax;
    tmax = 0;
    for (int r = 0; r < NT; r++) begin
      if (tbl[r].scen == scen) begin
        if (tbl[r].fall_at > tmax) tmax = tbl[r].fall_at;
        if (tbl[r].start + tbl[r].len + 8 > tmax) tmax = tbl[r].start + tbl[r].len + 8;
      end
    end
    tmax = tmax + 2;
    raw = raw_at(scen, 0);
    for (int t = 1; t <= tmax; t++) begin
      step();
      check($sformatf("scen%0d", scen), t, outs(), expect_at(scen, t));
      raw = raw_at(scen, t);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t got no finish expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    //             scen ch st len bat bl  prs lng rf  rl  fall clk
    tbl[0] = '{0, 0, 0, 10,  0, 0,  6,  0,  0,  0, 16, 1}; // short click
    tbl[1] = '{1, 1, 0,  3,  0, 0,  0,  0,  0,  0,  0, 0}; // 3-cycle glitch
    tbl[2] = '{2, 3, 0,  4,  0, 0,  6,  0,  0,  0, 10, 1}; // minimum press
    tbl[3] = '{3, 1, 0, 20,  0, 0,  6,  0,  0,  0, 26, 1}; // released on long edge
    tbl[4] = '{4, 2, 0, 50,  0, 0,  6, 26, 31, 51, 56, 0}; // long + repeat
    tbl[5] = '{5, 3, 0, 25,  0, 0,  6, 26,  0,  0, 31, 0}; // rep edge at exit
    tbl[6] = '{6, 1, 0, 27, 10, 3,  6, 26, 31, 31, 33, 0}; // bounce, rep in REL_DB
    tbl[7] = '{7, 3, 0, 35,  0, 0,  6, 26, 31, 36, 41, 0}; // ch3 long ...
    tbl[8] = '{7, 0, 5, 10,  0, 0, 11,  0,  0,  0, 21, 1}; // ... with ch0 click

    // Reset with all buttons pressed.
    rst = 1'b1;
    raw = 4'h0;
    repeat (3) step();
    check("reset_hold", 0, outs(), 20'h0);
    rst = 1'b0;
    for (int t = 1; t <= 14; t++) begin
      step();
      check("reset_release", t, outs(),
            pack((t >= 6 && t < 12) ? 4'hF : 4'h0, (t == 6) ? 4'hF : 4'h0,
                 (t == 12) ? 4'hF : 4'h0, 4'h0, 4'h0));
      if (t == 6) raw = 4'hF;
    end

    for (int s = 0; s < NS; s++) run_scen(s);

    // Asynchronous reset during the repeat phase.
    raw = 4'b1011;
    for (int t = 1; t <= 33; t++) begin
      step();
      check("midreset_pre", t, outs(),
            pack((t >= 6) ? 4'b0100 : 4'h0, (t == 6) ? 4'b0100 : 4'h0, 4'h0,
                 (t == 26) ? 4'b0100 : 4'h0, (t == 31) ? 4'b0100 : 4'h0));
    end
    #2;
    rst = 1'b1;
    #1;
    check("midreset_async", 0, outs(), 20'h0);
    step();
    step();
    check("midreset_hold", 0, outs(), 20'h0);
    rst = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      step();
      check("midreset_redebounce", t, outs(),
            pack((t >= 6) ? 4'b0100 : 4'h0, (t == 6) ? 4'b0100 : 4'h0, 4'h0, 4'h0, 4'h0));
    end
    raw = 4'hF;
    repeat (10) step();
    check("final_idle", 0, outs(), 20'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_events.md
# button_events

Parametrised N-channel pushbutton front end for the lab top level. Replaces per-button debounce instances with one block that synchronises raw inputs, debounces both press and release, and emits one-cycle press, click, long-press and auto-repeat events. Top-level counters and FSMs consume these events instead of free-running repeat counters.

## Interface
- N, default 4: number of button channels.
- CLK_HZ, default 50_000_000: clock frequency in Hz.
- DEBOUNCE_MS, default 20: stable time for both press and release. DB_TICKS = (CLK_HZ/1000)*DEBOUNCE_MS, must be ≥1.
- LONG_MS, default 600: hold time after the debounced press that makes the press long. LONG_TICKS = (CLK_HZ/1000)*LONG_MS, must be ≥2.
- REPEAT_MS, default 200: auto-repeat period once long. REP_TICKS = (CLK_HZ/1000)*REPEAT_MS. A value of 0 disables repeat.
- ACTIVE_LOW, default 1: 1 means raw inputs are active-low, as KEY is.
- clk  in  1  system clock, CLOCK_50 at top.
- reset  in  1  asynchronous, active-high reset.
- raw  in  N  unsynchronised button levels.
- held  out  N  debounced pressed level.
- press  out  N  one-cycle pulse when held rises.
- click  out  N  one-cycle pulse when held falls after a short press.
- long  out  N  one-cycle pulse when a press becomes long.
- rep  out  N  one-cycle auto-repeat pulse.

## Operation
- Per channel: p = raw XOR ACTIVE_LOW, passed through a 2-flop synchroniser to give s. The synchroniser resets to 0, which means not pressed.
- Per channel: 4-state FSM (IDLE, PRESS_DB, HELD, REL_DB), debounce counter dcnt, hold counter hcnt, and flag is_long.
- Transitions from IDLE:
  - s=1: go to PRESS_DB, dcnt←1.
  - DB_TICKS=1: go straight to HELD on this edge.
- Transitions from PRESS_DB:
  - s=0: go to IDLE, dcnt←0. This is a glitch; no output.
  - s=1 and dcnt=DB_TICKS-1: go to HELD; held←1, press pulse, hcnt←0, is_long←0.
  - Otherwise: dcnt++.
- HELD and REL_DB, hold counting: hcnt increments every cycle in either state.
  - Not long yet, hcnt=LONG_TICKS-1: long pulse, is_long←1, hcnt←0.
  - Long and REP_TICKS≠0, hcnt=REP_TICKS-1: rep pulse, hcnt←0.
  - Counter widths: max(clog2(LONG_TICKS), clog2(REP_TICKS)).
- Transitions from HELD:
  - s=0: go to REL_DB, dcnt←1.
- Transitions from REL_DB:
  - s=1: return to HELD, dcnt←0. hcnt and is_long are preserved.
  - s=0 and dcnt=DB_TICKS-1: go to IDLE; held←0; click pulse only if is_long=0.
  - Otherwise: dcnt++.
- Event ordering: press, long, rep and click are mutually exclusive within a channel in any cycle. Channels are fully independent.
- Reset mid-press: every output drops to 0 asynchronously. After reset is released, a button that is still pressed must debounce again from IDLE and produces a fresh press pulse.

## Timing
- Reset values: held, press, click, long and rep are all 0. FSM in IDLE. Counters and is_long are 0.
- All outputs are registered.
- Press latency: raw stably asserted at edge k gives held=1 and press=1 in the cycle after edge k+2+DB_TICKS. That is 2 synchroniser cycles plus DB_TICKS.
- Release latency: same, 2+DB_TICKS cycles after raw deasserts. click coincides with held falling.
- long: asserts exactly LONG_TICKS cycles after press.
- rep: first pulse REP_TICKS cycles after long, then every REP_TICKS cycles while held=1, including during REL_DB.
- Press glitch: a pulse at s shorter than DB_TICKS cycles produces no output.
- Release bounce: a gap at s shorter than DB_TICKS cycles while held does not drop held and does not restart long/rep timing.

## Test plan
Configuration for all scenarios: N=4, CLK_HZ=1000 (1 tick/ms), DEBOUNCE_MS=4, LONG_MS=20, REPEAT_MS=5, ACTIVE_LOW=1.
- Reset:
  - Stimulus: reset asserted with raw=4'b0000 (all pressed).
  - Response: all outputs 0. After release, press[3:0] pulses together 6 cycles later.
- Short click:
  - Stimulus: raw[0] low for 10 cycles, then high.
  - Response: press[0] at +6, held[0] high for 10 cycles, click[0] when held falls; no long/rep.
- Glitch rejection:
  - Stimulus: raw[1] low for 3 cycles; separately, raw[1] pressed with 3-cycle high bounces.
  - Response: no press for the first. The second keeps held[1]=1 and produces no extra press or click.
- Long plus repeat:
  - Stimulus: raw[2] low for 50 cycles.
  - Response: press at +6, long at +26, rep at +31, +36, +41, +46, +51. On release, held falls with no click.
- Simultaneous channels:
  - Stimulus: raw[0] short click while raw[3] held long.
  - Response: independent pulses; channel 3 timing is unaffected.
- Async reset mid-press:
  - Stimulus: reset asserted for 2 cycles during the repeat phase of the long + repeat scenario.
  - Response: outputs clear immediately. The press re-debounces and press pulses 6 cycles after reset deasserts.
